// File: rtl/pipelined_memory.sv
// Byte-addressable unified memory: N registered read ports, one byte-granular write
// port, range checking on every access and a zero-fill sweep after reset.
module pipelined_memory #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [63:0] MEM_BYTE_SIZE  = 64'h1000,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned DATA_BYTE_SIZE = DATA_WIDTH / 8,
  localparam int unsigned BYTE_IDX_W     = $clog2(DATA_BYTE_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 ready,
  input  logic [NUM_READ_PORTS-1:0]            rd_req,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS-1:0]            rd_valid,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_fault,
  input  logic [BYTE_IDX_W:0]                  wr_bytes,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_fault
);

  localparam int unsigned MEM_N  = 32'(MEM_BYTE_SIZE);
  localparam int unsigned MIDX_W = $clog2(MEM_N);
  localparam int unsigned PTR_W  = MIDX_W + 1;
  localparam int unsigned CNT_W  = BYTE_IDX_W + 1;
  localparam int unsigned EXT_W  = ADDR_WIDTH + 1;

  localparam logic [EXT_W-1:0] MEM_LIMIT = EXT_W'(MEM_BYTE_SIZE);
  localparam logic [EXT_W-1:0] WORD_EXT  = EXT_W'(DATA_BYTE_SIZE);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MEM_N - DATA_BYTE_SIZE);
  localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(DATA_BYTE_SIZE);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(DATA_BYTE_SIZE);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                                   state_q, state_d;
  logic [PTR_W-1:0]                         clear_ptr;
  logic [7:0]                               mem [MEM_N];
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_word;
  logic [NUM_READ_PORTS-1:0]                rd_oob;
  logic [CNT_W-1:0]                         wr_n;
  logic                                     wr_oob;
  logic                                     wr_go;

  // Sweep pointer and mode register; ready tracks the state the next cycle runs in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == READY);
      if (state_q == CLEAR) clear_ptr <= clear_ptr + PTR_STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clear_ptr == LAST_PTR) state_d = READY;
  end

  // Range checks are done one bit wider than the address so they cannot wrap.
  always_comb begin
    rd_word = '0;
    rd_oob  = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_oob[p] = ({1'b0, rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} + WORD_EXT) > MEM_LIMIT;
      for (int i = 0; i < DATA_BYTE_SIZE; i++)
        rd_word[p][8*i +: 8] = mem[rd_addr[p*ADDR_WIDTH +: MIDX_W] + MIDX_W'(i)];
    end
  end

  always_comb begin
    wr_n   = (wr_bytes > MAX_CNT) ? MAX_CNT : wr_bytes;
    wr_oob = ({1'b0, wr_addr} + EXT_W'(wr_n)) > MEM_LIMIT;
    wr_go  = (wr_n != '0) && !wr_oob;
  end

  // Storage update; the read registers sample mem before this lands (read-first).
  always_ff @(posedge clk) begin
    if (rst && state_q == CLEAR) begin
      for (int i = 0; i < DATA_BYTE_SIZE; i++)
        mem[clear_ptr[MIDX_W-1:0] + MIDX_W'(i)] <= 8'h00;
    end else if (rst && state_q == READY && wr_go) begin
      for (int i = 0; i < DATA_BYTE_SIZE; i++)
        if (CNT_W'(i) < wr_n) mem[wr_addr[MIDX_W-1:0] + MIDX_W'(i)] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_fault <= '0;
      rd_data  <= '0;
      wr_fault <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (state_q == READY && rd_req[p]) begin
          rd_valid[p]                     <= 1'b1;
          rd_fault[p]                     <= rd_oob[p];
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_oob[p] ? '0 : rd_word[p];
        end else begin
          rd_valid[p] <= 1'b0;
          rd_fault[p] <= 1'b0;
        end
      end
      wr_fault <= (state_q == READY) && (wr_n != '0) && wr_oob;
    end
  end

endmodule
